// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
//   Registered bitwise logic unit with an accumulator and an output FIFO.
//   Operand pairs are accepted over a valid/ready handshake. Each accepted
//   transaction computes one of eight bitwise operations on A and either B
//   or the accumulator. The result and its status flags are queued in a
//   DEPTH-entry FIFO.
//
//   Parameters
//     WIDTH     operand/result width in bits (>= 1)
//     DEPTH     output FIFO entries (power of two, >= 2)
//   Ports
//     clk       rising-edge clock
//     reset     asynchronous, active-high reset
//     in_valid  operand transaction present
//     in_ready  block can accept a transaction this cycle
//     A, B      operands (B ignored when acc_mode = 1)
//     op        operation select
//     acc_mode  1: use the accumulator in place of B
//     out_valid result present at FIFO head
//     out_ready consumer takes the head this cycle
//     Cout      result at FIFO head
//     zero      head result == 0
//     parity    XOR-reduction of head result
//     all_ones  head result == all ones
//     level     current FIFO occupancy
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         A,
    input  logic [WIDTH-1:0]         B,
    input  logic [2:0]               op,
    input  logic                     acc_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         Cout,
    output logic                     zero,
    output logic                     parity,
    output logic                     all_ones,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_NOR   = 3'b010,
        OP_XOR   = 3'b011,
        OP_NAND  = 3'b100,
        OP_XNOR  = 3'b101,
        OP_NOTA  = 3'b110,
        OP_PASSA = 3'b111
    } op_e;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             parity;
        logic             all_ones;
    } entry_t;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] r;
    entry_t           push_entry;
    entry_t           head;
    entry_t           mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    rptr_nxt;
    logic [LW-1:0]    level_nxt;
    logic             push;
    logic             pop;

    assign in_ready  = (level < LW'(DEPTH)) && !reset;
    assign out_valid = (level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign Cout      = head.data;
    assign zero      = head.zero;
    assign parity    = head.parity;
    assign all_ones  = head.all_ones;

    always_comb begin
        x = acc_mode ? acc : B;
        r = '0;
        case (op_e'(op))
            OP_AND:   r = A & x;
            OP_OR:    r = A | x;
            OP_NOR:   r = ~(A | x);
            OP_XOR:   r = A ^ x;
            OP_NAND:  r = ~(A & x);
            OP_XNOR:  r = ~(A ^ x);
            OP_NOTA:  r = ~A;
            OP_PASSA: r = A;
            default:  r = A;
        endcase
    end

    always_comb begin
        push_entry          = '0;
        push_entry.data     = r;
        push_entry.zero     = (r == '0);
        push_entry.parity   = ^r;
        push_entry.all_ones = &r;
    end

    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
        rptr_nxt = pop ? rptr + 1'b1 : rptr;
    end

    // Storage carries no reset: stale slots are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_entry;
        end
    end

    // The head is a register preloaded with the entry that will sit at the
    // read pointer after this edge, so outputs hold their last value when
    // the FIFO drains and read 0 after reset. When the slot being written
    // this edge becomes the head, the incoming entry is forwarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            head  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
                acc  <= r;
            end
            rptr  <= rptr_nxt;
            level <= level_nxt;
            if (level_nxt != '0) begin
                head <= (push && (wptr == rptr_nxt)) ? push_entry : mem[rptr_nxt];
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: an 8-bit/2-deep and a
// 16-bit/4-deep instance, a queue-based reference model checked every
// negative clock edge, and directed vectors with literal expectations.
module tb_logic_unit_pipe;

    logic clk = 1'b0;
    logic reset = 1'b0;

    // 8-bit, 2-deep instance
    logic       v8 = 0, r8, am8 = 0, ov8, or8 = 0, z8, p8, ao8;
    logic [7:0] a8 = 0, b8 = 0, c8;
    logic [2:0] op8 = 0;
    logic [1:0] l8;

    // 16-bit, 4-deep instance
    logic        v16 = 0, r16, am16 = 0, ov16, or16 = 0, z16, p16, ao16;
    logic [15:0] a16 = 0, b16 = 0, c16;
    logic [2:0]  op16 = 0;
    logic [2:0]  l16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .DEPTH(2)) dut8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in_ready(r8),
        .A(a8), .B(b8), .op(op8), .acc_mode(am8),
        .out_valid(ov8), .out_ready(or8), .Cout(c8),
        .zero(z8), .parity(p8), .all_ones(ao8), .level(l8)
    );

    logic_unit_pipe #(.WIDTH(16), .DEPTH(4)) dut16 (
        .clk(clk), .reset(reset), .in_valid(v16), .in_ready(r16),
        .A(a16), .B(b16), .op(op16), .acc_mode(am16),
        .out_valid(ov16), .out_ready(or16), .Cout(c16),
        .zero(z16), .parity(p16), .all_ones(ao16), .level(l16)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [15:0] lu(input int w, input logic [2:0] o,
                                       input logic [15:0] a, input logic [15:0] x);
        logic [15:0] m;
        logic [15:0] res;
        m = 16'((32'd1 << w) - 1);
        case (o)
            3'd0: res = a & x;
            3'd1: res = a | x;
            3'd2: res = ~(a | x);
            3'd3: res = a ^ x;
            3'd4: res = ~(a & x);
            3'd5: res = ~(a ^ x);
            3'd6: res = ~a;
            default: res = a;
        endcase
        return res & m;
    endfunction

    // entry = {zero, parity, all_ones, result[15:0]}
    function automatic logic [18:0] ent(input int w, input logic [15:0] r);
        logic [15:0] m;
        m = 16'((32'd1 << w) - 1);
        return {(r == 16'h0), ^r, (r == m), r};
    endfunction

    logic [18:0] q8[$];
    logic [18:0] q16[$];
    logic [15:0] acc8 = 0, acc16 = 0, mr;
    logic [18:0] h8 = 0, h16 = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q8.delete(); q16.delete();
            acc8 = 0; acc16 = 0; h8 = 0; h16 = 0;
        end else begin
            if (v8 && q8.size() < 2) begin
                mr = lu(8, op8, {8'h0, a8}, am8 ? acc8 : {8'h0, b8});
                if (q8.size() != 0 && or8) void'(q8.pop_front());
                q8.push_back(ent(8, mr));
                acc8 = mr;
            end else if (q8.size() != 0 && or8) begin
                void'(q8.pop_front());
            end
            if (q8.size() != 0) h8 = q8[0];

            if (v16 && q16.size() < 4) begin
                mr = lu(16, op16, a16, am16 ? acc16 : b16);
                if (q16.size() != 0 && or16) void'(q16.pop_front());
                q16.push_back(ent(16, mr));
                acc16 = mr;
            end else if (q16.size() != 0 && or16) begin
                void'(q16.pop_front());
            end
            if (q16.size() != 0) h16 = q16[0];
        end
    end

    // ---------------- compare process ----------------
    logic [18:0] seen8[$];
    logic [18:0] seen16[$];

    always @(negedge clk) begin
        chk("in_ready8",  {31'h0, r8},  {31'h0, (q8.size() < 2) && !reset});
        chk("out_valid8", {31'h0, ov8}, {31'h0, q8.size() != 0});
        chk("level8",     {30'h0, l8},  q8.size());
        chk("cout8",      {24'h0, c8},  {24'h0, h8[7:0]});
        chk("flags8",     {29'h0, z8, p8, ao8}, {29'h0, h8[18:16]});
        chk("in_ready16", {31'h0, r16}, {31'h0, (q16.size() < 4) && !reset});
        chk("out_valid16",{31'h0, ov16},{31'h0, q16.size() != 0});
        chk("level16",    {29'h0, l16}, q16.size());
        chk("cout16",     {16'h0, c16}, {16'h0, h16[15:0]});
        chk("flags16",    {29'h0, z16, p16, ao16}, {29'h0, h16[18:16]});
        if (!reset && ov8 && or8)   seen8.push_back({z8, p8, ao8, 8'h00, c8});
        if (!reset && ov16 && or16) seen16.push_back({z16, p16, ao16, c16});
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push16(input logic [15:0] a, input logic [2:0] o);
        int n;
        logic ok;
        n = 0;
        ok = 1'b0;
        v16 = 1'b1; a16 = a; op16 = o; am16 = 1'b0;
        while (!ok && n < 20) begin
            @(negedge clk);
            ok = r16;
            @(posedge clk);
            #2;
            n++;
        end
        if (!ok) chk("push16_timeout", 32'd0, 32'd1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0]  exp2 [8];
        logic [10:0] exp3 [5];
        logic [7:0]  exp4 [3];
        logic [15:0] val;
        exp2 = '{8'h05, 8'hAF, 8'h50, 8'hAA, 8'hFA, 8'h55, 8'h5A, 8'hA5};
        exp3 = '{{3'b100, 8'h00}, {3'b010, 8'h01}, {3'b000, 8'h81},
                 {3'b001, 8'hFF}, {3'b100, 8'h00}};
        exp4 = '{8'h11, 8'h22, 8'h33};

        #1 reset = 1'b1;
        cyc(2);
        @(negedge clk);
        chk("rst_in_ready8", {31'h0, r8}, 32'd0);
        chk("rst_cout8", {24'h0, c8}, 32'd0);
        chk("rst_flags8", {29'h0, z8, p8, ao8}, 32'd0);
        cyc();
        reset = 1'b0;

        // single NOR
        or8 = 1; v8 = 1; a8 = 8'hF0; b8 = 8'h3C; op8 = 3'b010; am8 = 0;
        cyc();
        v8 = 0;
        @(negedge clk);
        chk("t1_valid", {31'h0, ov8}, 32'd1);
        chk("t1_cout", {24'h0, c8}, 32'h03);
        chk("t1_flags", {29'h0, z8, p8, ao8}, 32'd0);
        cyc();

        // all eight ops, streaming
        seen8.delete();
        for (int i = 0; i < 8; i++) begin
            v8 = 1; a8 = 8'hA5; b8 = 8'h0F; op8 = 3'(i); am8 = 0;
            cyc();
        end
        v8 = 0;
        cyc(3);
        chk("t2_count", seen8.size(), 32'd8);
        for (int i = 0; i < 8 && i < seen8.size(); i++)
            chk($sformatf("t2_op%0d", i), {24'h0, seen8[i][7:0]}, {24'h0, exp2[i]});

        // accumulator chain (first transaction clears the accumulator)
        seen8.delete();
        v8 = 1; a8 = 8'h00; b8 = 8'h00; op8 = 3'b000; am8 = 0; cyc();
        am8 = 1; a8 = 8'h01; op8 = 3'b001; cyc();
        a8 = 8'h80; op8 = 3'b001; cyc();
        a8 = 8'h81; op8 = 3'b101; cyc();
        a8 = 8'hFF; op8 = 3'b011; cyc();
        v8 = 0; am8 = 0;
        cyc(3);
        chk("t3_count", seen8.size(), 32'd5);
        for (int i = 0; i < 5 && i < seen8.size(); i++)
            chk($sformatf("t3_chain%0d", i), {21'h0, seen8[i][18:16], seen8[i][7:0]}, {21'h0, exp3[i]});

        // backpressure
        seen8.delete();
        or8 = 0; v8 = 1; op8 = 3'b111; a8 = 8'h11; cyc();
        a8 = 8'h22; cyc();
        a8 = 8'h33; cyc();
        @(negedge clk);
        chk("t4_full_ready", {31'h0, r8}, 32'd0);
        chk("t4_full_level", {30'h0, l8}, 32'd2);
        cyc();
        or8 = 1; cyc();
        or8 = 0;
        @(negedge clk);
        chk("t4_pop_level", {30'h0, l8}, 32'd1);
        chk("t4_pop_ready", {31'h0, r8}, 32'd1);
        cyc();
        v8 = 0;
        @(negedge clk);
        chk("t4_refill_level", {30'h0, l8}, 32'd2);
        cyc();
        or8 = 1;
        cyc(3);
        chk("t4_count", seen8.size(), 32'd3);
        for (int i = 0; i < 3 && i < seen8.size(); i++)
            chk($sformatf("t4_order%0d", i), {24'h0, seen8[i][7:0]}, {24'h0, exp4[i]});

        // reset mid-stream
        or8 = 0; v8 = 1; op8 = 3'b111; a8 = 8'h44; cyc();
        a8 = 8'h55; cyc();
        v8 = 0;
        reset = 1'b1;
        #1;
        chk("t5_rst_valid", {31'h0, ov8}, 32'd0);
        chk("t5_rst_level", {30'h0, l8}, 32'd0);
        chk("t5_rst_cout", {24'h0, c8}, 32'd0);
        cyc();
        reset = 1'b0;
        or8 = 1; v8 = 1; a8 = 8'hFF; op8 = 3'b000; am8 = 1;
        cyc();
        v8 = 0; am8 = 0;
        @(negedge clk);
        chk("t5_valid", {31'h0, ov8}, 32'd1);
        chk("t5_cout", {24'h0, c8}, 32'h00);
        chk("t5_zero", {31'h0, z8}, 32'd1);
        cyc(2);

        // 16-bit, 4-deep: fill, then stream with wrap-around
        seen16.delete();
        or16 = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 4) begin
                v16 = 0;
                @(negedge clk);
                chk("t6_full_level", {29'h0, l16}, 32'd4);
                chk("t6_full_ready", {31'h0, r16}, 32'd0);
                cyc();
                or16 = 1;
            end
            val = 16'h0F0F + 16'(k) * 16'h1357;
            push16(val, (k % 2 == 1) ? 3'b110 : 3'b111);
        end
        v16 = 0;
        cyc(8);
        chk("t6_count", seen16.size(), 32'd12);
        for (int k = 0; k < 12 && k < seen16.size(); k++) begin
            val = 16'h0F0F + 16'(k) * 16'h1357;
            if (k % 2 == 1) val = ~val;
            chk($sformatf("t6_order%0d", k), {16'h0, seen16[k][15:0]}, {16'h0, val});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
